// File: rtl/disp_scan_ctrl.sv
// Two-digit-pair multiplexed display scanner: shows {seg0,seg2} then {seg1,seg3},
// with blank gaps between the pairs, a per-frame input snapshot and optional digit blinking.
module disp_scan_ctrl #(
  parameter int SCAN_DIV  = 8192,
  parameter int BLANK_CYC = 64,
  parameter int BLINK_DIV = 16
) (
  input  logic       clkt,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic       edit_en,
  input  logic [1:0] edit_digit,
  output logic       select_seg1,
  output logic       select_seg2,
  output logic [6:0] segAout,
  output logic [6:0] segBout,
  output logic       frame_tick
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FRM_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {SHOW0, GAP0, SHOW1, GAP1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [FRM_W-1:0] r_frame;
  logic             r_blink;
  logic [6:0]       r_snap0, r_snap1, r_snap2, r_snap3;
  logic             r_sel;
  logic [6:0]       r_seg_a, r_seg_b;
  logic             r_tick;

  logic             w_enter_show0;
  logic             w_tick;
  logic             w_wrap;
  logic             w_blink_nxt;
  logic             w_mask_en;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    if (!scan_en) begin
      w_state_nxt = GAP1;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        SHOW0: if (r_cnt == SCAN_LAST)  begin w_state_nxt = GAP0;  w_cnt_nxt = '0; end
        GAP0:  if (r_cnt == BLANK_LAST) begin w_state_nxt = SHOW1; w_cnt_nxt = '0; end
        SHOW1: if (r_cnt == SCAN_LAST)  begin w_state_nxt = GAP1;  w_cnt_nxt = '0; end
        GAP1:  if (r_cnt == BLANK_LAST) begin w_state_nxt = SHOW0; w_cnt_nxt = '0; end
        default: begin w_state_nxt = GAP1; w_cnt_nxt = '0; end
      endcase
    end
  end

  always_ff @(posedge clkt or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= GAP1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs lag the state by one cycle; the blink phase used for masking is the
  // post-update value so a whole frame sees one consistent phase.
  assign w_enter_show0 = scan_en && (r_state == GAP1) && (r_cnt == BLANK_LAST);
  assign w_tick        = scan_en && (r_state == SHOW0) && (r_cnt == '0);
  assign w_wrap        = w_tick && (r_frame == FRM_LAST);
  assign w_blink_nxt   = w_wrap ? ~r_blink : r_blink;
  assign w_mask_en     = edit_en && w_blink_nxt;

  always_ff @(posedge clkt or negedge rst_n) begin
    if (!rst_n) begin
      r_snap0 <= '0;
      r_snap1 <= '0;
      r_snap2 <= '0;
      r_snap3 <= '0;
    end else if (w_enter_show0) begin
      r_snap0 <= seg0;
      r_snap1 <= seg1;
      r_snap2 <= seg2;
      r_snap3 <= seg3;
    end
  end

  always_ff @(posedge clkt or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_blink <= 1'b0;
    end else if (w_tick) begin
      r_frame <= w_wrap ? '0 : r_frame + FRM_W'(1);
      r_blink <= w_blink_nxt;
    end
  end

  always_ff @(posedge clkt or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= 1'b0;
      r_seg_a <= '0;
      r_seg_b <= '0;
      r_tick  <= 1'b0;
    end else if (!scan_en) begin
      r_sel   <= 1'b0;
      r_seg_a <= '0;
      r_seg_b <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_tick;
      unique case (r_state)
        SHOW0: begin
          r_sel   <= 1'b0;
          r_seg_a <= (w_mask_en && edit_digit == 2'd0) ? 7'h00 : r_snap0;
          r_seg_b <= (w_mask_en && edit_digit == 2'd2) ? 7'h00 : r_snap2;
        end
        SHOW1: begin
          r_sel   <= 1'b1;
          r_seg_a <= (w_mask_en && edit_digit == 2'd1) ? 7'h00 : r_snap1;
          r_seg_b <= (w_mask_en && edit_digit == 2'd3) ? 7'h00 : r_snap3;
        end
        default: begin
          r_seg_a <= '0;
          r_seg_b <= '0;
        end
      endcase
    end
  end

  assign select_seg1 = r_sel;
  assign select_seg2 = r_sel;
  assign segAout     = r_seg_a;
  assign segBout     = r_seg_b;
  assign frame_tick  = r_tick;

endmodule
